// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch stage: opcode values, IR field
// positions and the fetch handshake state encoding.
package sisc_pkg;

   localparam logic [3:0] OP_NOOP   = 4'd0;
   localparam logic [3:0] OP_LOD    = 4'd1;
   localparam logic [3:0] OP_STR    = 4'd2;
   localparam logic [3:0] OP_SWP    = 4'd3;
   localparam logic [3:0] OP_BRA    = 4'd4;
   localparam logic [3:0] OP_BRR    = 4'd5;
   localparam logic [3:0] OP_BNE    = 4'd6;
   localparam logic [3:0] OP_BNR    = 4'd7;
   localparam logic [3:0] OP_ALU_OP = 4'd8;
   localparam logic [3:0] OP_HLT    = 4'd15;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam int MM_MSB  = 27;
   localparam int MM_LSB  = 24;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface sisc_fetch_unit_if #(
   parameter int PC_W = 16,
   parameter int IR_W = 32
);
   logic [PC_W-1:0] imem_addr;
   logic            imem_req;
   logic            imem_ack;
   logic [IR_W-1:0] imem_rdata;

   modport master (output imem_addr, output imem_req, input imem_ack, input imem_rdata);
   modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/sisc_next_pc.sv
// Next-PC computation: increment, absolute branch (zero-extended immediate)
// or PC-relative branch (sign-extended immediate), all modulo 2^PC_W.
module sisc_next_pc #(
   parameter int PC_W = 16
) (
   input  logic [PC_W-1:0] pc,
   input  logic [15:0]     imm,
   input  logic            pc_sel,
   input  logic            br_sel,
   output logic [PC_W-1:0] next_pc
);
   localparam int EXT_W = (PC_W > 16) ? PC_W : 16;

   logic [EXT_W-1:0] w_imm_zext;
   logic [EXT_W-1:0] w_imm_sext;

   assign w_imm_zext = EXT_W'(imm);
   assign w_imm_sext = EXT_W'($signed(imm));

   // Select the candidate PC; overflow wraps silently.
   always_comb begin
      next_pc = pc;
      if (!pc_sel) begin
         next_pc = pc + PC_W'(1'b1);
      end else if (br_sel) begin
         next_pc = w_imm_zext[PC_W-1:0];
      end else begin
         next_pc = pc + w_imm_sext[PC_W-1:0];
      end
   end
endmodule

// File: rtl/sisc_fetch_unit.sv
// PC and instruction register stage: updates the PC under FSM control and
// fetches instructions over a req/ack handshake into the IR.
module sisc_fetch_unit
   import sisc_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter int              IR_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pc_rst,
   input  logic                    pc_write,
   input  logic                    pc_sel,
   input  logic                    br_sel,
   input  logic                    ir_load,
   sisc_fetch_unit_if.master       imem,
   output logic [PC_W-1:0]         pc,
   output logic [IR_W-1:0]         ir,
   output logic [3:0]              opcode,
   output logic [3:0]              mm,
   output logic                    ir_valid,
   output logic                    fetch_busy,
   output logic                    fetch_err
);
   fetch_state_t    r_state;
   logic [PC_W-1:0] r_pc;
   logic [IR_W-1:0] r_ir;
   logic            r_ir_valid;
   logic [PC_W-1:0] r_imem_addr;
   logic            r_imem_req;
   logic            r_busy;
   logic            r_err;
   logic [PC_W-1:0] w_next_pc;

   sisc_next_pc #(.PC_W(PC_W)) u_next_pc (
      .pc      (r_pc),
      .imm     (r_ir[IMM_MSB:IMM_LSB]),
      .pc_sel  (pc_sel),
      .br_sel  (br_sel),
      .next_pc (w_next_pc)
   );

   // PC update and fetch handshake FSM; rst overrides everything, even mid-fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_pc        <= RESET_PC;
         r_ir        <= {OP_NOOP, {(IR_W-4){1'b0}}};
         r_ir_valid  <= 1'b0;
         r_imem_addr <= '0;
         r_imem_req  <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (pc_rst) begin
            r_pc <= RESET_PC;
         end else if (pc_write) begin
            r_pc <= w_next_pc;
         end

         case (r_state)
            ST_IDLE: begin
               // The fetch address is the PC before any same-edge update.
               if (ir_load && !pc_rst) begin
                  r_imem_addr <= r_pc;
                  r_imem_req  <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (ir_load) begin
                  r_err <= 1'b1;
               end
               if (imem.imem_ack) begin
                  if (!pc_rst) begin
                     r_ir       <= imem.imem_rdata;
                     r_ir_valid <= 1'b1;
                  end
                  r_imem_req <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end else if (pc_rst) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (ir_load) begin
                  r_err <= 1'b1;
               end
               // Data for a fetch cancelled by pc_rst is dropped.
               if (imem.imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_imem_req <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign imem.imem_addr = r_imem_addr;
   assign imem.imem_req  = r_imem_req;
   assign pc             = r_pc;
   assign ir             = r_ir;
   assign opcode         = r_ir[OPC_MSB:OPC_LSB];
   assign mm             = r_ir[MM_MSB:MM_LSB];
   assign ir_valid       = r_ir_valid;
   assign fetch_busy     = r_busy;
   assign fetch_err      = r_err;
endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed testbench for sisc_fetch_unit with hand-computed expectations.
module tb_sisc_fetch_unit;
   import sisc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_rst;
   logic        pc_write;
   logic        pc_sel;
   logic        br_sel;
   logic        ir_load;
   logic [15:0] pc;
   logic [31:0] ir;
   logic [3:0]  opcode;
   logic [3:0]  mm;
   logic        ir_valid;
   logic        fetch_busy;
   logic        fetch_err;

   int n_checks = 0;
   int n_fail   = 0;

   sisc_fetch_unit_if #(.PC_W(16), .IR_W(32)) imem ();

   sisc_fetch_unit #(.PC_W(16), .IR_W(32), .RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_rst     (pc_rst),
      .pc_write   (pc_write),
      .pc_sel     (pc_sel),
      .br_sel     (br_sel),
      .ir_load    (ir_load),
      .imem       (imem),
      .pc         (pc),
      .ir         (ir),
      .opcode     (opcode),
      .mm         (mm),
      .ir_valid   (ir_valid),
      .fetch_busy (fetch_busy),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Advance one posedge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      ir_load  = 1'b0;
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = 32'h0000_0000;
   endtask

   // Fetch from current PC with a zero-wait acknowledge.
   task automatic fetch(input logic [31:0] data);
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = data;
      tick();
      imem.imem_ack   = 1'b0;
   endtask

   task automatic pc_op(input logic sel, input logic br);
      pc_write = 1'b1;
      pc_sel   = sel;
      br_sel   = br;
      tick();
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_pc",       32'(pc), 32'h0);
      chk("rst_ir",       ir, 32'h0);
      chk("rst_opcode",   32'(opcode), 32'(OP_NOOP));
      chk("rst_req",      32'(imem.imem_req), 32'h0);
      chk("rst_busy",     32'(fetch_busy), 32'h0);
      chk("rst_ir_valid", 32'(ir_valid), 32'h0);
      chk("rst_err",      32'(fetch_err), 32'h0);

      // Fetch at PC 5 with 3 wait states while incrementing the PC.
      for (int i = 0; i < 5; i++) pc_op(1'b0, 1'b0);
      chk("pc_five", 32'(pc), 32'h5);
      ir_load  = 1'b1;
      pc_write = 1'b1;
      tick();
      ir_load  = 1'b0;
      pc_write = 1'b0;
      chk("t2_pc_inc", 32'(pc), 32'h6);
      for (int i = 0; i < 3; i++) begin
         chk("t2_wait_req",  32'(imem.imem_req), 32'h1);
         chk("t2_wait_addr", 32'(imem.imem_addr), 32'h5);
         chk("t2_wait_busy", 32'(fetch_busy), 32'h1);
         tick();
      end
      chk("t2_ack_busy", 32'(fetch_busy), 32'h1);
      chk("t2_ack_addr", 32'(imem.imem_addr), 32'h5);
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 32'h8000_1234;
      tick();
      imem.imem_ack   = 1'b0;
      chk("t2_ir",       ir, 32'h8000_1234);
      chk("t2_opcode",   32'(opcode), 32'(OP_ALU_OP));
      chk("t2_mm",       32'(mm), 32'h0);
      chk("t2_ir_valid", 32'(ir_valid), 32'h1);
      chk("t2_busy",     32'(fetch_busy), 32'h0);
      chk("t2_req",      32'(imem.imem_req), 32'h0);

      // Ack with req low must be ignored.
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 32'hF000_0000;
      tick();
      imem.imem_ack   = 1'b0;
      chk("ack_idle_ir",   ir, 32'h8000_1234);
      chk("ack_idle_busy", 32'(fetch_busy), 32'h0);

      // Absolute, relative, and wrap-around PC updates.
      fetch(32'h4000_0040);
      pc_op(1'b1, 1'b1);
      chk("t3_abs", 32'(pc), 32'h0040);
      fetch(32'h5000_FFFE);
      chk("t3_fetch_addr", 32'(imem.imem_addr), 32'h0040);
      pc_op(1'b1, 1'b0);
      chk("t3_rel", 32'(pc), 32'h003E);
      fetch(32'h4000_FFFF);
      pc_op(1'b1, 1'b1);
      chk("t3_abs_ffff", 32'(pc), 32'hFFFF);
      pc_op(1'b0, 1'b0);
      chk("t3_wrap", 32'(pc), 32'h0000);

      // pc_rst during WAIT drains the fetch and discards its data.
      pc_op(1'b0, 1'b0);
      pc_op(1'b0, 1'b0);
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      pc_rst  = 1'b1;
      tick();
      pc_rst  = 1'b0;
      chk("t4_pc",   32'(pc), 32'h0);
      chk("t4_req",  32'(imem.imem_req), 32'h1);
      chk("t4_addr", 32'(imem.imem_addr), 32'h2);
      chk("t4_busy", 32'(fetch_busy), 32'h1);
      tick();
      chk("t4_req_hold", 32'(imem.imem_req), 32'h1);
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 32'hF000_0000;
      tick();
      imem.imem_ack   = 1'b0;
      chk("t4_ir",     ir, 32'h4000_FFFF);
      chk("t4_opcode", 32'(opcode), 32'(OP_BRA));
      chk("t4_busy_after", 32'(fetch_busy), 32'h0);
      chk("t4_req_after",  32'(imem.imem_req), 32'h0);

      // ir_load while busy sets the sticky error and issues nothing new.
      ir_load = 1'b1;
      tick();
      tick();
      ir_load = 1'b0;
      chk("t5_err",  32'(fetch_err), 32'h1);
      chk("t5_req",  32'(imem.imem_req), 32'h1);
      chk("t5_addr", 32'(imem.imem_addr), 32'h0);
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 32'h1000_0003;
      tick();
      imem.imem_ack   = 1'b0;
      chk("t5_ir",       ir, 32'h1000_0003);
      chk("t5_opcode",   32'(opcode), 32'(OP_LOD));
      tick();
      chk("t5_no_second", 32'(imem.imem_req), 32'h0);
      chk("t5_err_sticky", 32'(fetch_err), 32'h1);

      // rst mid-WAIT returns everything to reset values.
      pc_op(1'b0, 1'b0);
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5r_req",      32'(imem.imem_req), 32'h0);
      chk("t5r_addr",     32'(imem.imem_addr), 32'h0);
      chk("t5r_busy",     32'(fetch_busy), 32'h0);
      chk("t5r_pc",       32'(pc), 32'h0);
      chk("t5r_ir",       ir, 32'h0);
      chk("t5r_ir_valid", 32'(ir_valid), 32'h0);
      chk("t5r_err",      32'(fetch_err), 32'h0);

      // pc_rst beats a same-edge branch; pc_rst blocks a same-edge ir_load.
      fetch(32'h4000_0077);
      pc_op(1'b0, 1'b0);
      chk("t6_pc_one", 32'(pc), 32'h1);
      pc_rst = 1'b1;
      pc_op(1'b1, 1'b1);
      pc_rst = 1'b0;
      chk("t6_pcrst_branch", 32'(pc), 32'h0);
      pc_rst  = 1'b1;
      ir_load = 1'b1;
      tick();
      pc_rst  = 1'b0;
      ir_load = 1'b0;
      chk("t6_no_req",  32'(imem.imem_req), 32'h0);
      chk("t6_no_busy", 32'(fetch_busy), 32'h0);
      chk("t6_no_err",  32'(fetch_err), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
- Program-counter and instruction-register stage directly upstream of the SISC control FSM.
- Holds the PC and computes the next PC from the FSM's pc_sel/br_sel/pc_write/pc_rst.
- Fetches 32-bit instructions from instruction memory over a req/ack handshake and latches them into the IR.
- Presents opcode and mm fields to the FSM, with a busy flag that stalls the FSM while a fetch is outstanding.

Parameters:
- PC_W, 16: PC and instruction-address width.
- IR_W, 32: instruction width.
- RESET_PC, 0: PC value after rst or pc_rst.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pc_rst  in  1  FSM PC reset (synchronous, active-high).
- pc_write  in  1  FSM PC update enable.
- pc_sel  in  1  0 = increment, 1 = branch target.
- br_sel  in  1  branch mode: 1 = absolute, 0 = PC-relative.
- ir_load  in  1  FSM fetch request (one-cycle pulse).
- imem_addr  out  PC_W  registered fetch address.
- imem_req  out  1  registered memory request.
- imem_ack  in  1  memory data valid for the current request.
- imem_rdata  in  IR_W  instruction data, valid when imem_ack=1.
- pc  out  PC_W  current PC.
- ir  out  IR_W  instruction register.
- opcode  out  4  ir[31:28].
- mm  out  4  ir[27:24] (condition code / addressing mode).
- ir_valid  out  1  IR holds a fetched instruction.
- fetch_busy  out  1  fetch outstanding; FSM must hold its state.
- fetch_err  out  1  sticky: ir_load arrived while busy.

Behaviour:
- rst (highest priority, any state, including mid-fetch) sets:
  - pc=RESET_PC, ir=0 (NOOP), ir_valid=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, state=IDLE.
  - The memory model must tolerate req dropping without an ack.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE, ir_load=1, pc_rst=0: imem_addr<=pc (pre-update value), imem_req<=1, fetch_busy<=1, go to WAIT.
  - WAIT, imem_ack=1: ir<=imem_rdata, ir_valid<=1, imem_req<=0, fetch_busy<=0, go to IDLE.
  - WAIT, pc_rst=1 and no ack in the same cycle: go to DRAIN; req stays high, busy stays 1.
  - DRAIN, imem_ack=1: discard data (ir unchanged), req<=0, busy<=0, go to IDLE.
  - WAIT, pc_rst=1 and ack in the same cycle: go straight to IDLE, data discarded.
- Handshake rules:
  - imem_req and imem_addr stay stable from assertion until the cycle ack is sampled.
  - ack is ignored when req=0.
  - ack is allowed in the first cycle req is high.
- Latency: ir_load edge N, req high during cycle N+1; ack in N+1 gives IR updated at edge N+2 and busy low after N+2. Each wait cycle adds one.
- ir_load while in WAIT or DRAIN: ignored; fetch_err<=1 (sticky until rst).
- PC update, per posedge, in priority order:
  1. pc_rst=1: pc<=RESET_PC.
  2. pc_write=1, pc_sel=0: pc<=pc+1.
  3. pc_write=1, pc_sel=1, br_sel=1: pc<=ir[15:0] zero-extended/truncated to PC_W.
  4. pc_write=1, pc_sel=1, br_sel=0: pc<=pc+sext(ir[15:0]).
  5. Otherwise: hold.
- PC arithmetic is modulo 2^PC_W; wrap-around is silent (0xFFFF+1=0x0000).
- pc_write is honoured in any fetch state. The fetch address was already latched, so ir_load+pc_write on the same edge fetches the old PC and increments.
- Branch targets always use the current IR, not an in-flight fetch.
- opcode, mm and ir are registered and stable between IR loads. ir_valid is cleared only by rst.

Decomposition:
- Shared package sisc_pkg:
  - opcode constants: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15.
  - IR field positions: opcode 31:28, mm 27:24, imm 15:0.
  - fetch state encoding (IDLE/WAIT/DRAIN).
- One combinational sub-module sisc_next_pc: inputs pc, imm, pc_sel, br_sel; output next PC including sign extension.
- The handshake FSM and registers stay in sisc_fetch_unit.

Test Plan:
1. rst for 2 cycles, then release: pc=0, ir=0, opcode=0, req=0, busy=0, ir_valid=0.
2. pc=0x0005, pulse ir_load+pc_write (pc_sel=0), memory acks after 3 wait cycles with 0x8000_1234: imem_addr=0x0005 throughout, pc=0x0006 next cycle, busy high 4 cycles, then ir=0x80001234, opcode=8, mm=0, ir_valid=1.
3. ir=0x4000_0040, pc=0x0010, pc_write+pc_sel+br_sel=1 -> pc=0x0040. Then ir=0x5000_FFFE, br_sel=0 -> pc=0x003E. Then pc=0xFFFF, increment -> pc=0x0000.
4. pc_rst asserted during WAIT, ack 2 cycles later with 0xF000_0000: pc=0 immediately, req held until ack, ir unchanged (opcode does not become 15), busy drops after ack.
5. ir_load pulsed again while busy -> fetch_err=1 and stays 1, no second request issued. rst mid-WAIT -> req=0 and all outputs at reset values next cycle.
6. pc_rst and pc_write (branch) on the same edge -> pc=RESET_PC. pc_rst and ir_load on the same edge in IDLE -> no request issued.
